// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, immediate-select codes and controller state encoding for the
// 3-stage RV32I pipeline sequencing logic.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Same codes as the 3-bit select of imm_gen.
    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5
    } imm_sel_e;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StMemWait,
        StErr
    } state_e;

endpackage

// File: rtl/inst_decode.sv
// ID-stage instruction decode: immediate type for imm_gen and source-register usage
// for the load-use hazard check.
module inst_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] i_inst,
    input  logic        i_valid,
    output logic [2:0]  o_imm_sel,
    output logic        o_rs1_used,
    output logic        o_rs2_used,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2
);

    imm_sel_e   w_type;
    logic [6:0] w_opcode;
    logic       w_unused;

    assign w_opcode = i_inst[6:0];
    assign w_unused = ^{i_inst[31:25], i_inst[14:7]};

    always_comb begin
        w_type = ImmNone;
        case (w_opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: w_type = ImmI;
            OP_STORE:                            w_type = ImmS;
            OP_BRANCH:                           w_type = ImmB;
            OP_LUI, OP_AUIPC:                    w_type = ImmU;
            OP_JAL:                              w_type = ImmJ;
            default:                             w_type = ImmNone;
        endcase
    end

    assign o_imm_sel  = i_valid ? w_type : ImmNone;
    assign o_rs1_used = (w_type != ImmU) && (w_type != ImmJ);
    assign o_rs2_used = (w_opcode == OP_REG) || (w_type == ImmS) || (w_type == ImmB);
    assign o_rs1      = i_inst[19:15];
    assign o_rs2      = i_inst[24:20];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flush across the
// one-cycle IMEM latency, data-memory hold with watchdog, and performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_id_inst,
    input  logic             i_id_valid,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_busy,
    output logic [2:0]       o_imm_sel,
    output logic             o_pc_stall,
    output logic             o_id_stall,
    output logic             o_ex_hold,
    output logic             o_ex_bubble,
    output logic             o_id_flush,
    output logic             o_pc_redirect,
    output logic             o_err,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int unsigned   WD_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);

    state_e           r_state, w_state_d;
    logic [WD_W-1:0]  r_wd, w_wd_d, w_wd_inc;
    logic [CNT_W-1:0] r_cycle, r_stall, r_flush;
    logic             w_rs1_used, w_rs2_used, w_load_use;
    logic [4:0]       w_rs1, w_rs2;

    inst_decode u_decode (
        .i_inst     (i_id_inst),
        .i_valid    (i_id_valid),
        .o_imm_sel  (o_imm_sel),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used),
        .o_rs1      (w_rs1),
        .o_rs2      (w_rs2)
    );

    assign w_load_use = i_ex_valid && i_ex_is_load && (i_ex_rd != 5'd0) && i_id_valid &&
                        ((w_rs1_used && (w_rs1 == i_ex_rd)) || (w_rs2_used && (w_rs2 == i_ex_rd)));

    // The first busy cycle is counted in RUN/FLUSH, so the count restarts at one there.
    assign w_wd_inc = (r_state == StMemWait) ? r_wd + WD_W'(1) : WD_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StRun;
            r_wd    <= '0;
            r_cycle <= '0;
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            r_state <= w_state_d;
            r_wd    <= w_wd_d;
            r_cycle <= r_cycle + CNT_W'(1);
            r_stall <= r_stall + {{(CNT_W-1){1'b0}}, o_pc_stall};
            r_flush <= r_flush + {{(CNT_W-1){1'b0}}, o_pc_redirect};
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_wd_d    = '0;
        case (r_state)
            StErr: w_state_d = StErr;
            default: begin
                if (i_mem_busy) begin
                    w_wd_d    = w_wd_inc;
                    w_state_d = (w_wd_inc >= WD_MAX) ? StErr : StMemWait;
                end else if ((r_state != StFlush) && i_ex_br_taken) begin
                    w_state_d = StFlush;
                end else begin
                    w_state_d = StRun;
                end
            end
        endcase
    end

    always_comb begin
        o_pc_stall    = 1'b0;
        o_id_stall    = 1'b0;
        o_ex_hold     = 1'b0;
        o_ex_bubble   = 1'b0;
        o_id_flush    = 1'b0;
        o_pc_redirect = 1'b0;
        if (i_rst_n) begin
            if ((r_state == StErr) || i_mem_busy) begin
                o_pc_stall = 1'b1;
                o_id_stall = 1'b1;
                o_ex_hold  = 1'b1;
            end else if (r_state == StFlush) begin
                // Kill the wrong-path fetch; a load-use on it is irrelevant.
                o_id_flush  = 1'b1;
                o_ex_bubble = 1'b1;
            end else if (i_ex_br_taken) begin
                o_pc_redirect = 1'b1;
                o_id_flush    = 1'b1;
                o_ex_bubble   = 1'b1;
            end else if (w_load_use) begin
                o_pc_stall  = 1'b1;
                o_id_stall  = 1'b1;
                o_ex_bubble = 1'b1;
            end
        end
    end

    assign o_err       = (r_state == StErr);
    assign o_cycle_cnt = r_cycle;
    assign o_stall_cnt = r_stall;
    assign o_flush_cnt = r_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model
// of the pipeline controller.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_inst;
    logic        id_valid, ex_valid, ex_is_load, br, busy;
    logic [4:0]  ex_rd;
    logic [2:0]  imm_sel;
    logic        pc_stall, id_stall, ex_hold, ex_bubble, id_flush, pc_redirect, err;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [5:0]  ctl;

    int n_vec = 0;
    int n_err = 0;

    // Control vector: {pc_stall, id_stall, ex_hold, ex_bubble, id_flush, pc_redirect}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_HOLD = 6'b111000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_BR   = 6'b000111;
    localparam logic [5:0] C_FL   = 6'b000110;

    logic [6:0]  ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6f, 7'h33, 7'h7f};
    logic [31:0] dec_inst [5] = '{32'h06400093, 32'h00112023, 32'h00208463,
                                  32'h000010b7, 32'h008000ef};
    logic [2:0]  dec_exp [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

    always #5 clk = ~clk;

    assign ctl = {pc_stall, id_stall, ex_hold, ex_bubble, id_flush, pc_redirect};

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (32)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_id_inst     (id_inst),
        .i_id_valid    (id_valid),
        .i_ex_valid    (ex_valid),
        .i_ex_is_load  (ex_is_load),
        .i_ex_rd       (ex_rd),
        .i_ex_br_taken (br),
        .i_mem_busy    (busy),
        .o_imm_sel     (imm_sel),
        .o_pc_stall    (pc_stall),
        .o_id_stall    (id_stall),
        .o_ex_hold     (ex_hold),
        .o_ex_bubble   (ex_bubble),
        .o_id_flush    (id_flush),
        .o_pc_redirect (pc_redirect),
        .o_err         (err),
        .o_cycle_cnt   (cycle_cnt),
        .o_stall_cnt   (stall_cnt),
        .o_flush_cnt   (flush_cnt)
    );

    function automatic logic [2:0] ref_imm(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
            7'h23:                      return 3'd2;
            7'h63:                      return 3'd3;
            7'h37, 7'h17:               return 3'd4;
            7'h6f:                      return 3'd5;
            default:                    return 3'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_inst = 32'h0; id_valid = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
        ex_rd = 5'd0; br = 1'b0; busy = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; id_valid = 1'b1; id_inst = 32'h06400093; busy = 1'b1; br = 1'b1;
        #1;
        n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE); end
        n_vec++; if (imm_sel !== 3'd1) begin n_err++; $display("FAIL reset_imm: got %0d want 1", imm_sel); end
        tick();
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if ({cycle_cnt, stall_cnt, flush_cnt} !== 96'h0) begin
            n_err++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", cycle_cnt, stall_cnt, flush_cnt);
        end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        apply_reset();
        id_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            id_inst = dec_inst[i];
            #1;
            n_vec++; if (imm_sel !== dec_exp[i]) begin
                n_err++; $display("FAIL decode_%0d: got %0d want %0d", i, imm_sel, dec_exp[i]);
            end
        end
        id_valid = 1'b0;
        #1;
        n_vec++; if (imm_sel !== 3'd0) begin n_err++; $display("FAIL decode_invalid: got %0d want 0", imm_sel); end
        tick();
    endtask

    task automatic test_load_use();
        apply_reset();
        id_valid = 1'b1; id_inst = 32'h00728333; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        #1;
        n_vec++; if (ctl !== C_LU) begin n_err++; $display("FAIL lu_stall: got %b want %b", ctl, C_LU); end
        tick();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        #1;
        n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL lu_release: got %b want %b", ctl, C_NONE); end
        tick();
        n_vec++; if (stall_cnt !== 32'd1 || cycle_cnt !== 32'd2) begin
            n_err++; $display("FAIL lu_cnt: got stall %0d cycle %0d want 1 2", stall_cnt, cycle_cnt);
        end
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; id_inst = 32'h00000333;
        #1;
        n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL lu_x0: got %b want %b", ctl, C_NONE); end
        ex_rd = 5'd5; id_inst = 32'h000282b7;
        #1;
        n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL lu_lui: got %b want %b", ctl, C_NONE); end
        tick();
    endtask

    task automatic test_branch();
        apply_reset();
        br = 1'b1;
        #1;
        n_vec++; if (ctl !== C_BR) begin n_err++; $display("FAIL br_c0: got %b want %b", ctl, C_BR); end
        tick();
        // Still asserted in FLUSH: must be ignored.
        #1;
        n_vec++; if (ctl !== C_FL) begin n_err++; $display("FAIL br_c1: got %b want %b", ctl, C_FL); end
        tick();
        br = 1'b0;
        #1;
        n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL br_c2: got %b want %b", ctl, C_NONE); end
        tick();
        n_vec++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
            n_err++; $display("FAIL br_cnt: got flush %0d stall %0d want 1 0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_hold();
        apply_reset();
        busy = 1'b1; br = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (ctl !== C_HOLD) begin n_err++; $display("FAIL hold_c%0d: got %b want %b", i, ctl, C_HOLD); end
            tick();
        end
        busy = 1'b0;
        #1;
        n_vec++; if (ctl !== C_BR) begin n_err++; $display("FAIL hold_redirect: got %b want %b", ctl, C_BR); end
        tick();
        br = 1'b0;
        n_vec++; if (stall_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
            n_err++; $display("FAIL hold_cnt: got stall %0d flush %0d want 3 1", stall_cnt, flush_cnt);
        end
        tick();
    endtask

    task automatic test_watchdog();
        apply_reset();
        busy = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_vec++; if (err !== (k >= int'(TO))) begin
                n_err++; $display("FAIL wd_err_%0d: got %b want %b", k, err, k >= int'(TO));
            end
        end
        busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (ctl !== C_HOLD || err !== 1'b1) begin
                n_err++; $display("FAIL wd_sticky_%0d: got ctl %b err %b want %b 1", k, ctl, err, C_HOLD);
            end
            tick();
        end
        n_vec++; if (stall_cnt !== 32'd23) begin n_err++; $display("FAIL wd_stall_cnt: got %0d want 23", stall_cnt); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL wd_clear: got %b want 0", err); end
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        br = 1'b1;
        tick();
        br = 1'b0; rst_n = 1'b0;
        #1;
        n_vec++; if (ctl !== C_NONE) begin n_err++; $display("FAIL rmf_in_reset: got %b want %b", ctl, C_NONE); end
        tick();
        rst_n = 1'b1;
        #1;
        n_vec++; if (ctl !== C_NONE || err !== 1'b0) begin
            n_err++; $display("FAIL rmf_after: got ctl %b err %b want %b 0", ctl, err, C_NONE);
        end
        n_vec++; if ({cycle_cnt, stall_cnt, flush_cnt} !== 96'h0) begin
            n_err++; $display("FAIL rmf_cnt: got %0d/%0d/%0d want 0/0/0", cycle_cnt, stall_cnt, flush_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        logic        m_err, m_fp, e_lu, rs1u, rs2u;
        int          m_streak, burst;
        logic [31:0] m_cyc, m_stl, m_fl, inst;
        logic [5:0]  e_ctl;
        logic [2:0]  e_imm, t;
        logic [6:0]  op;
        apply_reset();
        m_err = 1'b0; m_fp = 1'b0; m_streak = 0; burst = 0;
        m_cyc = '0; m_stl = '0; m_fl = '0;
        for (int i = 0; i < 1500; i++) begin
            op   = ops[$urandom_range(0, 10)];
            inst = $urandom();
            inst[6:0]   = op;
            inst[19:15] = 5'($urandom_range(0, 3));
            inst[24:20] = 5'($urandom_range(0, 3));
            id_inst    = inst;
            id_valid   = ($urandom_range(0, 3) != 0);
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_is_load = 1'($urandom_range(0, 1));
            ex_rd      = 5'($urandom_range(0, 3));
            br         = ($urandom_range(0, 3) == 0);
            if (burst == 0 && $urandom_range(0, 9) == 0)
                burst = ($urandom_range(0, 14) == 0) ? 17 : int'($urandom_range(1, 5));
            busy = (burst != 0);
            if (burst != 0) burst--;
            rst_n = ($urandom_range(0, 99) >= 2);

            t     = ref_imm(op);
            e_imm = id_valid ? t : 3'd0;
            rs1u  = !(t == 3'd4 || t == 3'd5);
            rs2u  = (op == 7'h33) || t == 3'd2 || t == 3'd3;
            e_lu  = ex_valid && ex_is_load && ex_rd != 5'd0 && id_valid &&
                    ((rs1u && inst[19:15] == ex_rd) || (rs2u && inst[24:20] == ex_rd));
            if (!rst_n)              e_ctl = C_NONE;
            else if (m_err || busy)  e_ctl = C_HOLD;
            else if (m_fp)           e_ctl = C_FL;
            else if (br)             e_ctl = C_BR;
            else if (e_lu)           e_ctl = C_LU;
            else                     e_ctl = C_NONE;
            #1;
            n_vec++; if (ctl !== e_ctl || imm_sel !== e_imm) begin
                n_err++; $display("FAIL rnd_ctl@%0d: got ctl %b imm %0d want %b %0d", i, ctl, imm_sel, e_ctl, e_imm);
            end
            tick();
            if (!rst_n) begin
                m_err = 1'b0; m_fp = 1'b0; m_streak = 0; m_cyc = '0; m_stl = '0; m_fl = '0;
            end else begin
                m_cyc++;
                m_stl += {31'd0, e_ctl[5]};
                m_fl  += {31'd0, e_ctl[0]};
                if (!m_err) begin
                    if (busy) begin
                        m_streak++;
                        m_fp = 1'b0;
                        if (m_streak >= int'(TO)) m_err = 1'b1;
                    end else begin
                        m_streak = 0;
                        m_fp = m_fp ? 1'b0 : br;
                    end
                end
            end
            n_vec++; if (err !== m_err || cycle_cnt !== m_cyc || stall_cnt !== m_stl || flush_cnt !== m_fl) begin
                n_err++;
                $display("FAIL rnd_state@%0d: got err %b cnt %0d/%0d/%0d want %b %0d/%0d/%0d",
                         i, err, cycle_cnt, stall_cnt, flush_cnt, m_err, m_cyc, m_stl, m_fl);
            end
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_decode();
        test_load_use();
        test_branch();
        test_mem_hold();
        test_watchdog();
        test_reset_mid_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 3-stage RV32I core: IF, ID, and EX/MEM-WB.
- Decodes the ID-stage instruction into the immediate-generator select and register-use flags.
- Detects load-use hazards.
- Sequences taken-branch flushes across the one-cycle synchronous IMEM latency.
- Holds the whole pipe while data memory is busy, with a watchdog.
- Keeps free-running performance counters.

It drives the stall, flush and bubble controls of the PC, IF/ID and ID/EX registers, and `imm_sel` of `imm_gen`.

## Interface
Clocking and reset: one clock; reset is synchronous and active-low.

Parameters:
- `MEM_TIMEOUT`, default 15: maximum consecutive `mem_busy` cycles before error.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  synchronous active-low reset.
- `id_inst`  in  32  instruction in the IF/ID register.
- `id_valid`  in  1  `id_inst` is a real instruction.
- `ex_valid`  in  1  EX stage holds a real instruction.
- `ex_is_load`  in  1  EX instruction is a load.
- `ex_rd`  in  5  EX destination register.
- `ex_br_taken`  in  1  EX branch/jump resolved taken this cycle.
- `mem_busy`  in  1  data-memory access outstanding.
- `imm_sel`  out  3  immediate type for `imm_gen`.
- `pc_stall`  out  1  hold PC.
- `id_stall`  out  1  hold IF/ID.
- `ex_hold`  out  1  hold ID/EX and EX/MEM.
- `ex_bubble`  out  1  load a NOP into ID/EX.
- `id_flush`  out  1  invalidate IF/ID.
- `pc_redirect`  out  1  select the branch target as next PC.
- `err`  out  1  memory watchdog tripped (sticky).
- `cycle_cnt`, `stall_cnt`, `flush_cnt`  out  `CNT_W` each  performance counters.

## Operation
Decode (combinational from `id_inst[6:0]`; forced to NONE when `id_valid`=0):
- `0010011`, `0000011`, `1100111`, `1110011` → I (1).
- `0100011` → S (2).
- `1100011` → B (3).
- `0110111`, `0010111` → U (4).
- `1101111` → J (5).
- Anything else → NONE (0).
- rs1 is used unless U or J. rs2 is used for `0110011`, S and B.

Load-use hazard:
- `load_use` = `ex_valid` & `ex_is_load` & (`ex_rd` ≠ 0) & `id_valid` & ((rs1 used & rs1 == `ex_rd`) | (rs2 used & rs2 == `ex_rd`)).

State machine (states RUN, FLUSH, MEM_WAIT, ERR). Per-cycle priority: ERR > `mem_busy` > `ex_br_taken` > `load_use`.
- **RUN**
  - `mem_busy`: `pc_stall`, `id_stall`, `ex_hold` = 1; next state MEM_WAIT; watchdog = 1.
  - Else `ex_br_taken`: `pc_redirect`, `id_flush`, `ex_bubble` = 1; next state FLUSH.
  - Else `load_use`: `pc_stall`, `id_stall`, `ex_bubble` = 1; stay in RUN.
  - Otherwise all controls 0.
- **FLUSH**
  - `id_flush` = 1, which kills the wrong-path fetch still in flight.
  - `ex_bubble` = 1 because the IF/ID contents were already invalidated.
  - Next state RUN. Priority still applies: `mem_busy` here behaves as in RUN.
  - `ex_br_taken` in FLUSH is ignored (EX holds a bubble).
- **MEM_WAIT**
  - Full hold, same as the RUN `mem_busy` case; the watchdog increments each cycle.
  - `mem_busy`=0 → RUN in the same cycle the controls are released. A branch pending in EX is then serviced in that cycle by normal RUN priority.
  - Watchdog reaching `MEM_TIMEOUT` with `mem_busy` still 1 → ERR.
- **ERR**
  - `pc_stall`, `id_stall`, `ex_hold` = 1 permanently; `err` = 1.
  - Exit only by reset.

Counters:
- `cycle_cnt` increments every cycle out of reset.
- `stall_cnt` increments each cycle `pc_stall`=1.
- `flush_cnt` increments each cycle `pc_redirect`=1.
- All counters wrap modulo 2^`CNT_W`.

## Timing
- Reset (`rst_n`=0 at posedge):
  - State RUN; watchdog 0; `err` 0; all counters 0.
  - During reset, control outputs are 0 and `imm_sel` follows decode.
- `imm_sel`, the stall/flush/bubble controls and `pc_redirect` are combinational from the current state and inputs. There is zero-cycle latency to the datapath registers, which sample them at the next edge.
- State, watchdog, `err` and the counters update on posedge.
- Branch penalty: 2 cycles (redirect cycle plus FLUSH).
- Load-use penalty: 1 bubble. The next cycle the load is in MEM, so the hazard clears without FSM state.
- `mem_busy` and `ex_br_taken` in the same cycle: hold wins. The branch stays in EX and is taken on the first non-busy cycle.
- Watchdog: `err` rises on the edge after the `MEM_TIMEOUT`-th consecutive busy cycle.
- Reset asserted mid-FLUSH or mid-MEM_WAIT returns to RUN on that edge.

## Structure
- Package `pipe_ctrl_pkg`:
  - opcode constants.
  - 3-bit `imm_sel` encodings: NONE/I/S/B/U/J = 0–5. `imm_gen` is widened to 3-bit select with the same codes.
  - state enum.
- Sub-module `inst_decode`, purely combinational, outputs `imm_sel`, `rs1_used`, `rs2_used`, rs1, rs2.
- The FSM, watchdog and counters live in `pipe_hazard_ctrl`.

## Test plan
- **Decode:** `id_inst`=`0x06400093` (addi x1,x0,100) → `imm_sel`=1.
  - `0x00112023` (sw) → 2.
  - `0x00208463` (beq) → 3.
  - `0x000010b7` (lui) → 4.
  - `0x008000ef` (jal) → 5.
  - `id_valid`=0 → 0.
- **Load-use:** `ex_is_load`=1, `ex_rd`=5, ID `add x6,x5,x7` → `pc_stall`=`id_stall`=`ex_bubble`=1 for exactly one cycle; `stall_cnt` +1.
  - Same with `ex_rd`=0, or a `lui x5` in ID → no stall.
- **Branch:** `ex_br_taken` pulse → cycle 0 `pc_redirect`=`id_flush`=1, cycle 1 `id_flush`=1 and `pc_redirect`=0, cycle 2 all 0; `flush_cnt`=1.
- **Memory hold:** `mem_busy` high for 3 cycles with `ex_br_taken`=1 → full hold for 3 cycles, redirect on cycle 4, `stall_cnt`=3.
- **Watchdog:** `mem_busy` held for 20 cycles with `MEM_TIMEOUT`=15 → `err`=1 after cycle 15 and stays set after `mem_busy` drops; `rst_n`=0 clears it.
- **Reset mid-FLUSH:** all outputs 0 on the following cycle and counters 0.
